// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the FFT frame controller: controller state encoding
// and the bit layout of the word sent on the FFT core config channel.
package fft_ctrl_pkg;

   // Controller states; IDLE must stay 0 so the reset value is the idle state.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CFG    = 2'd1,
      ST_STREAM = 2'd2,
      ST_DONE   = 2'd3
   } fft_state_e;

   // Config word layout: bit 0 selects forward/inverse, the scaling schedule
   // sits directly above it, remaining upper bits are zero padding.
   localparam int CFG_FWD_BIT = 0;
   localparam int CFG_SCH_LSB = 1;

endpackage

// File: rtl/fft_frame_ctrl.sv
// FFT frame controller: sends one config word to the FFT core, then passes
// upstream samples through with zero latency, framing them into NFFT-sample
// frames with tlast, for a programmed number of frames or until aborted.
module fft_frame_ctrl
   import fft_ctrl_pkg::*;
#(
   parameter int NFFT   = 1024,
   parameter int DATA_W = 64,
   parameter int CFG_W  = 24,
   parameter int SCH_W  = 10,
   parameter int FCNT_W = 16
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              start,
   input  logic              fwd_inv,
   input  logic [SCH_W-1:0]  scale_sch,
   input  logic [FCNT_W-1:0] num_frames,
   input  logic              abort,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   output logic [DATA_W-1:0] m_axis_data_tdata,
   output logic              m_axis_data_tvalid,
   input  logic              m_axis_data_tready,
   output logic              m_axis_data_tlast,
   output logic [CFG_W-1:0]  m_axis_config_tdata,
   output logic              m_axis_config_tvalid,
   input  logic              m_axis_config_tready,
   input  logic              event_tlast_unexpected,
   input  logic              event_tlast_missing,
   output logic              busy,
   output logic              done,
   output logic [FCNT_W-1:0] frames_done,
   output logic              err
);

   localparam int CNT_W = $clog2(NFFT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NFFT - 1);

   fft_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              fwd_q, fwd_d;
   logic [SCH_W-1:0]  sch_q, sch_d;
   logic [FCNT_W-1:0] nfr_q, nfr_d;
   logic [FCNT_W-1:0] frames_q, frames_d;
   logic              err_q, err_d;
   logic              abort_pend_q, abort_pend_d;

   logic              in_stream;
   logic              abort_any;
   logic              stop_now;
   logic              data_open;
   logic              data_hs;
   logic              cfg_hs;
   logic              last_frame;
   logic [FCNT_W:0]   frames_inc;

   // Data-path gating: samples flow only in STREAM, and are blocked in the
   // cycle where an abort ends the run at a frame boundary.
   always_comb begin
      in_stream          = (state_q == ST_STREAM);
      abort_any          = abort | abort_pend_q;
      stop_now           = in_stream && (cnt_q == '0) && abort_any;
      data_open          = in_stream && !stop_now;
      m_axis_data_tdata  = s_axis_tdata;
      m_axis_data_tvalid = data_open & s_axis_tvalid;
      s_axis_tready      = data_open & m_axis_data_tready;
      m_axis_data_tlast  = in_stream && (cnt_q == CNT_LAST);
      data_hs            = m_axis_data_tvalid & m_axis_data_tready;
      cfg_hs             = m_axis_config_tvalid & m_axis_config_tready;
      frames_inc         = {1'b0, frames_q} + {{FCNT_W{1'b0}}, 1'b1};
      last_frame         = (frames_inc == {1'b0, nfr_q});
   end

   // Config word and status outputs, all decoded from registered state.
   always_comb begin
      m_axis_config_tdata                         = '0;
      m_axis_config_tdata[CFG_FWD_BIT]            = fwd_q;
      m_axis_config_tdata[CFG_SCH_LSB +: SCH_W]   = sch_q;
      m_axis_config_tvalid                        = (state_q == ST_CFG);
      busy                                        = (state_q != ST_IDLE);
      done                                        = (state_q == ST_DONE);
      frames_done                                 = frames_q;
      err                                         = err_q;
   end

   // Next-state logic: run sequencing, sample/frame counting, abort handling.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      fwd_d        = fwd_q;
      sch_d        = sch_q;
      nfr_d        = nfr_q;
      frames_d     = frames_q;
      err_d        = err_q;
      abort_pend_d = abort_pend_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               fwd_d        = fwd_inv;
               sch_d        = scale_sch;
               nfr_d        = (num_frames == '0) ? {{(FCNT_W-1){1'b0}}, 1'b1} : num_frames;
               frames_d     = '0;
               err_d        = 1'b0;
               cnt_d        = '0;
               abort_pend_d = 1'b0;
               state_d      = ST_CFG;
            end
         end
         ST_CFG: begin
            // An abort here only takes effect once the config word is out.
            if (abort) abort_pend_d = 1'b1;
            if (cfg_hs) state_d = ST_STREAM;
         end
         ST_STREAM: begin
            if (abort) abort_pend_d = 1'b1;
            if (stop_now) begin
               state_d = ST_DONE;
            end else if (data_hs) begin
               if (m_axis_data_tlast) begin
                  cnt_d = '0;
                  if (frames_q != '1) frames_d = frames_inc[FCNT_W-1:0];
                  if (last_frame || abort_any) state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_DONE: begin
            abort_pend_d = 1'b0;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Core framing events are sticky and win over the clear done by start.
      if (event_tlast_unexpected || event_tlast_missing) err_d = 1'b1;
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         fwd_q        <= 1'b0;
         sch_q        <= '0;
         nfr_q        <= '0;
         frames_q     <= '0;
         err_q        <= 1'b0;
         abort_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         fwd_q        <= fwd_d;
         sch_q        <= sch_d;
         nfr_q        <= nfr_d;
         frames_q     <= frames_d;
         err_q        <= err_d;
         abort_pend_q <= abort_pend_d;
      end
   end

endmodule
